ttc_frame_align_ctrl: RTL and testbench

Frame-alignment controller for the TTC receive path. It takes the recovered serial bit stream and a per-bit enable, and hunts for the sync word. It steps the deserializer sampling phase on hunt timeout, declares lock after consecutive aligned sync words, then delivers 16-bit frames. It drops lock on repeated downstream frame errors or on a resync request, and sits between the bit recovery logic and the frame decoder.

---
 rtl/ttc_frame_align_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_ttc_frame_align_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ttc_frame_align_ctrl.sv
// ttc_frame_align_ctrl
// Frame-alignment controller for the TTC receive path. It hunts for the sync
// word in the recovered serial stream, steps the deserializer sampling phase
// when the hunt times out, and declares lock after LOCK_COUNT sync words in a
// row that are each 16 bits apart. Once locked it delivers every 16-bit
// frame. It drops lock after UNLOCK_ERRORS errored frames in a row, or when a
// resync is requested.
//
// Ports:
//   clk160        system clock
//   rst           asynchronous active-high reset
//   bit_in        recovered serial bit, valid when bit_en=1
//   bit_en        one recovered bit present this cycle
//   frame_err     decoder error flag for the frame presented on the previous cycle
//   resync        single-cycle request to restart the hunt
//   frame_valid   one-cycle pulse, frame_data valid
//   frame_data    aligned frame, first-received bit in bit 15
//   locked        high while in LOCKED
//   phase_sel     sampling-phase select to the deserializer
//   phase_step    one-cycle pulse when phase_sel changes
//   state         0 HUNT, 1 VERIFY, 2 LOCKED
//   lock_loss_cnt LOCKED->HUNT transitions, saturating at 255
module ttc_frame_align_ctrl #(
  parameter logic [15:0] SYNC_WORD     = 16'h817E,
  parameter int          LOCK_COUNT    = 4,
  parameter int          UNLOCK_ERRORS = 4,
  parameter int          HUNT_TIMEOUT  = 256
) (
  input  logic        clk160,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_en,
  input  logic        frame_err,
  input  logic        resync,
  output logic        frame_valid,
  output logic [15:0] frame_data,
  output logic        locked,
  output logic [1:0]  phase_sel,
  output logic        phase_step,
  output logic [1:0]  state,
  output logic [7:0]  lock_loss_cnt
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]  LOCK_LAST    = 4'(LOCK_COUNT);
  localparam logic [3:0]  UNLOCK_LAST  = 4'(UNLOCK_ERRORS);
  localparam logic [15:0] TIMEOUT_LAST = 16'(HUNT_TIMEOUT - 1);

  // Saturating increment for the lock-loss counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  state_t      state_r;
  logic [15:0] sr_r;
  logic [3:0]  bit_cnt_r;
  logic [3:0]  match_cnt_r;
  logic [3:0]  err_cnt_r;
  logic [15:0] timeout_r;
  logic        frame_valid_r;
  logic        fv_d_r;
  logic [15:0] frame_data_r;
  logic        locked_r;
  logic [1:0]  phase_sel_r;
  logic        phase_step_r;
  logic [7:0]  lock_loss_cnt_r;

  logic [15:0] sr_next_s;
  logic        sync_hit_s;
  logic        word_end_s;
  logic        frame_due_s;
  logic        err_sample_s;

  assign sr_next_s    = {sr_r[14:0], bit_in};
  assign sync_hit_s   = (sr_next_s == SYNC_WORD);
  assign word_end_s   = bit_en && (bit_cnt_r == 4'd15);
  assign frame_due_s  = (state_r == ST_LOCKED) && word_end_s;
  // fv_d_r is high exactly on the cycle after a frame_valid pulse, which is
  // the only cycle on which the decoder's error flag refers to our frame.
  assign err_sample_s = (state_r == ST_LOCKED) && fv_d_r;

  // Alignment FSM, counters, shift register and all registered outputs.
  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      state_r         <= ST_HUNT;
      sr_r            <= 16'h0000;
      bit_cnt_r       <= 4'd0;
      match_cnt_r     <= 4'd0;
      err_cnt_r       <= 4'd0;
      timeout_r       <= 16'd0;
      frame_valid_r   <= 1'b0;
      fv_d_r          <= 1'b0;
      frame_data_r    <= 16'h0000;
      locked_r        <= 1'b0;
      phase_sel_r     <= 2'd0;
      phase_step_r    <= 1'b0;
      lock_loss_cnt_r <= 8'd0;
    end else begin
      frame_valid_r <= 1'b0;
      phase_step_r  <= 1'b0;
      fv_d_r        <= frame_valid_r;

      if (bit_en) begin
        sr_r <= sr_next_s;
      end else begin
        sr_r <= sr_r;
      end

      // A due frame is delivered even when resync lands on the same cycle.
      if (frame_due_s) begin
        frame_valid_r <= 1'b1;
        frame_data_r  <= sr_next_s;
      end else begin
        frame_data_r  <= frame_data_r;
      end

      if (resync) begin
        state_r     <= ST_HUNT;
        locked_r    <= 1'b0;
        bit_cnt_r   <= 4'd0;
        match_cnt_r <= 4'd0;
        err_cnt_r   <= 4'd0;
        timeout_r   <= 16'd0;
        if (state_r == ST_LOCKED) begin
          lock_loss_cnt_r <= sat_inc8(lock_loss_cnt_r);
        end else begin
          lock_loss_cnt_r <= lock_loss_cnt_r;
        end
      end else begin
        case (state_r)
          ST_HUNT: begin
            if (bit_en) begin
              // A sync match wins over a same-cycle timeout.
              if (sync_hit_s) begin
                state_r     <= ST_VERIFY;
                bit_cnt_r   <= 4'd0;
                match_cnt_r <= 4'd1;
                timeout_r   <= 16'd0;
              end else if (timeout_r == TIMEOUT_LAST) begin
                phase_sel_r  <= phase_sel_r + 2'd1;
                phase_step_r <= 1'b1;
                timeout_r    <= 16'd0;
              end else begin
                timeout_r <= timeout_r + 16'd1;
              end
            end else begin
              timeout_r <= timeout_r;
            end
          end

          ST_VERIFY: begin
            if (bit_en) begin
              if (bit_cnt_r == 4'd15) begin
                bit_cnt_r <= 4'd0;
                if (sync_hit_s) begin
                  match_cnt_r <= match_cnt_r + 4'd1;
                  if ((match_cnt_r + 4'd1) == LOCK_LAST) begin
                    state_r   <= ST_LOCKED;
                    locked_r  <= 1'b1;
                    err_cnt_r <= 4'd0;
                  end else begin
                    state_r <= ST_VERIFY;
                  end
                end else begin
                  state_r     <= ST_HUNT;
                  match_cnt_r <= 4'd0;
                  timeout_r   <= 16'd0;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r;
            end
          end

          ST_LOCKED: begin
            if (bit_en) begin
              bit_cnt_r <= bit_cnt_r + 4'd1;  // wraps 15 -> 0 at each frame end
            end else begin
              bit_cnt_r <= bit_cnt_r;
            end
            if (err_sample_s) begin
              if (frame_err) begin
                if ((err_cnt_r + 4'd1) == UNLOCK_LAST) begin
                  state_r         <= ST_HUNT;
                  locked_r        <= 1'b0;
                  lock_loss_cnt_r <= sat_inc8(lock_loss_cnt_r);
                  match_cnt_r     <= 4'd0;
                  timeout_r       <= 16'd0;
                  err_cnt_r       <= 4'd0;
                  bit_cnt_r       <= 4'd0;
                end else begin
                  err_cnt_r <= err_cnt_r + 4'd1;
                end
              end else begin
                err_cnt_r <= 4'd0;
              end
            end else begin
              err_cnt_r <= err_cnt_r;
            end
          end

          default: begin
            state_r  <= ST_HUNT;
            locked_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign frame_valid   = frame_valid_r;
  assign frame_data    = frame_data_r;
  assign locked        = locked_r;
  assign phase_sel     = phase_sel_r;
  assign phase_step    = phase_step_r;
  assign state         = state_r;
  assign lock_loss_cnt = lock_loss_cnt_r;

endmodule

// File: tb/tb_ttc_frame_align_ctrl.sv
// Scoreboard bench for ttc_frame_align_ctrl. Stimulus pushes the expected
// frame (data plus arrival cycle) and expected phase-step cycles into queues.
// A monitor on the falling edge pops and compares whenever the DUT pulses
// frame_valid or phase_step.
module tb_ttc_frame_align_ctrl;

  logic        clk160 = 1'b0;
  logic        rst;
  logic        bit_in;
  logic        bit_en;
  logic        frame_err;
  logic        resync;
  logic        frame_valid;
  logic [15:0] frame_data;
  logic        locked;
  logic [1:0]  phase_sel;
  logic        phase_step;
  logic [1:0]  state;
  logic [7:0]  lock_loss_cnt;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] cyc      = 32'd0;
  logic [31:0] last_fv_cyc = 32'd0;
  logic [31:0] prev_fv_cyc = 32'd0;

  logic [15:0] exp_data_q[$];
  logic [31:0] exp_cyc_q[$];
  logic [31:0] exp_step_q[$];

  ttc_frame_align_ctrl dut (
    .clk160        (clk160),
    .rst           (rst),
    .bit_in        (bit_in),
    .bit_en        (bit_en),
    .frame_err     (frame_err),
    .resync        (resync),
    .frame_valid   (frame_valid),
    .frame_data    (frame_data),
    .locked        (locked),
    .phase_sel     (phase_sel),
    .phase_step    (phase_step),
    .state         (state),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk160 = ~clk160;

  always @(posedge clk160) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every frame / phase step against the scoreboard queues.
  always @(negedge clk160) begin
    if (rst === 1'b0) begin
      if (frame_valid) begin
        prev_fv_cyc = last_fv_cyc;
        last_fv_cyc = cyc;
        chk("frame_expected", 32'(exp_data_q.size() != 0), 32'd1);
        if (exp_data_q.size() != 0) begin
          chk("frame_data", 32'(frame_data), 32'(exp_data_q.pop_front()));
          chk("frame_cycle", cyc, exp_cyc_q.pop_front());
        end
      end
      if (phase_step) begin
        chk("step_expected", 32'(exp_step_q.size() != 0), 32'd1);
        if (exp_step_q.size() != 0) begin
          chk("step_cycle", cyc, exp_step_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input logic b, input logic en);
    bit_in = b;
    bit_en = en;
    @(posedge clk160);
    #1;
  endtask

  // Send one 16-bit word MSB first; err is the decoder flag for the previous
  // frame. With alt set, every bit is preceded by an idle (bit_en=0) cycle.
  task automatic send_word(input logic [15:0] w, input bit alt, input bit expf, input logic err);
    frame_err = err;
    for (int i = 15; i >= 0; i--) begin
      if (alt) tick(1'b0, 1'b0);
      if (i == 0 && expf) begin
        exp_data_q.push_back(w);
        exp_cyc_q.push_back(cyc + 32'd1);
      end
      tick(w[i], 1'b1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_frame_data"}, 32'(frame_data), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_phase_sel"}, 32'(phase_sel), 32'd0);
    chk({tag, "_phase_step"}, 32'(phase_step), 32'd0);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_lock_loss"}, 32'(lock_loss_cnt), 32'd0);
  endtask

  logic [15:0] err_words[10];
  logic        err_flags[10];

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_en = 1'b0; frame_err = 1'b0; resync = 1'b0;
    repeat (3) @(posedge clk160);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // All-zero stream: phase steps at bits 256 and 512, stays in HUNT.
    for (int i = 1; i <= 600; i++) begin
      if (i == 256 || i == 512) exp_step_q.push_back(cyc + 32'd1);
      tick(1'b0, 1'b1);
    end
    chk("zero_phase_sel", 32'(phase_sel), 32'd2);
    chk("zero_state", 32'(state), 32'd0);

    // Continuous sync stream: HUNT -> VERIFY -> LOCKED after 64 bits.
    send_word(16'h817E, 1'b0, 1'b0, 1'b0);
    chk("sync_w1_state", 32'(state), 32'd1);
    send_word(16'h817E, 1'b0, 1'b0, 1'b0);
    send_word(16'h817E, 1'b0, 1'b0, 1'b0);
    chk("sync_w3_locked", 32'(locked), 32'd0);
    send_word(16'h817E, 1'b0, 1'b0, 1'b0);
    chk("sync_w4_state", 32'(state), 32'd2);
    chk("sync_w4_locked", 32'(locked), 32'd1);
    send_word(16'h817E, 1'b0, 1'b1, 1'b0);
    send_word(16'h817E, 1'b0, 1'b1, 1'b0);

    // Data frames after lock.
    send_word(16'hF0F0, 1'b0, 1'b1, 1'b0);
    send_word(16'hF0F1, 1'b0, 1'b1, 1'b0);
    send_word(16'hF0F2, 1'b0, 1'b1, 1'b0);
    chk("data_state", 32'(state), 32'd2);

    // Error run: 3 errors then a clean frame keeps lock; then 4 errors drop it.
    // err_flags[k] is the decoder flag for the frame before err_words[k].
    err_flags = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 10; k++) begin
      err_words[k] = 16'hC3A0 + 16'(k);
      send_word(err_words[k], 1'b0, (k < 9), err_flags[k]);
      if (k == 4) chk("err_recover_state", 32'(state), 32'd2);
      if (k == 8) chk("err_three_state", 32'(state), 32'd2);
    end
    chk("err_unlock_state", 32'(state), 32'd0);
    chk("err_unlock_locked", 32'(locked), 32'd0);
    chk("err_lock_loss", 32'(lock_loss_cnt), 32'd1);

    // Two sync words then a bad word: back to HUNT, never locks.
    send_word(16'h817E, 1'b0, 1'b0, 1'b0);
    chk("partial_w1_locked", 32'(locked), 32'd0);
    send_word(16'h817E, 1'b0, 1'b0, 1'b0);
    chk("partial_w2_state", 32'(state), 32'd1);
    send_word(16'h1234, 1'b0, 1'b0, 1'b0);
    chk("partial_bad_state", 32'(state), 32'd0);
    chk("partial_bad_locked", 32'(locked), 32'd0);

    // bit_en on alternate cycles: lock after 64 bits, frames 32 cycles apart.
    for (int k = 0; k < 3; k++) send_word(16'h817E, 1'b1, 1'b0, 1'b0);
    chk("alt_w3_state", 32'(state), 32'd1);
    send_word(16'h817E, 1'b1, 1'b0, 1'b0);
    chk("alt_w4_locked", 32'(locked), 32'd1);
    send_word(16'h817E, 1'b1, 1'b1, 1'b0);
    send_word(16'h817E, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("alt_spacing", last_fv_cyc - prev_fv_cyc, 32'd32);

    // resync while LOCKED.
    resync = 1'b1;
    tick(1'b0, 1'b0);
    resync = 1'b0;
    chk("resync_state", 32'(state), 32'd0);
    chk("resync_locked", 32'(locked), 32'd0);
    chk("resync_lock_loss", 32'(lock_loss_cnt), 32'd2);
    chk("resync_phase_sel", 32'(phase_sel), 32'd2);

    // Relock, then assert rst in the middle of a frame.
    for (int k = 0; k < 4; k++) send_word(16'h817E, 1'b0, 1'b0, 1'b0);
    chk("relock_state", 32'(state), 32'd2);
    chk("relock_frame_data", 32'(frame_data), 32'h817E);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(posedge clk160);
    #1;
    rst = 1'b0;
    bit_en = 1'b0;
    tick(1'b0, 1'b0);

    chk("frames_left", 32'(exp_data_q.size()), 32'd0);
    chk("steps_left", 32'(exp_step_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
